// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver. The serial line is brought into the
// rx_clock domain through a two-flop synchroniser. The start bit is
// qualified at mid-bit, the data bits and stop bit(s) are sampled at mid-bit,
// and each finished frame produces a one-cycle done or framing-error strobe.
module uart_rx #(
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned stop_bit_count = 1
) (
  input  logic       rx_clock,
  input  logic       rx_reset_n,
  input  logic       rx_enable,
  input  logic       rx_input,
  output logic [7:0] rx_output,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       rx_frame_error
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);
  localparam logic [2:0]      StopLast = 3'(stop_bit_count - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  logic            sync1_q, sync2_q;
  logic            rxs;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            err_q, err_d;
  logic [7:0]      out_q, out_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge rx_clock or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_input;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // Frame state, counters, shift register and registered output strobes.
  always_ff @(posedge rx_clock or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: start qualification, mid-bit sampling, stop check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    err_d   = err_q;
    out_d   = out_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    if (!rx_enable) begin
      // Disable aborts the frame; the last byte stays on rx_output.
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_d = '0;
            idx_d = '0;
            // A line that is already high again at mid-start was a glitch.
            state_d = rxs ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == FullLast) begin
            cnt_d          = '0;
            shift_d[idx_q] = rxs;
            if (idx_q == 3'd7) begin
              state_d = StStop;
              idx_d   = '0;
              err_d   = 1'b0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == FullLast) begin
            cnt_d = '0;
            if (idx_q == StopLast) begin
              out_d = shift_q;
              idx_d = '0;
              err_d = 1'b0;
              if (err_q || !rxs) begin
                ferr_d  = 1'b1;
                state_d = StWaitHigh;
              end else begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
            end else begin
              idx_d = idx_q + 3'd1;
              if (!rxs) begin
                err_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitHigh: begin
          // Hold off until the line is released so a break is not read as 0x00.
          if (rxs) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign rx_output      = out_q;
  assign rx_done        = done_q;
  assign rx_frame_error = ferr_q;
  assign rx_busy        = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a table of frames on a one-stop-bit
// receiver, hand sequences for glitch, abort and mid-frame reset, and a
// two-stop-bit receiver for the second-stop framing check. Expected strobes
// are queued when a frame is driven and matched against observed strobes.
module tb_uart_rx;

  localparam int unsigned Os      = 16;
  localparam int          LatOne  = 155;  // raw start edge to strobe, 1 stop bit
  localparam int          LatTwo  = 171;  // raw start edge to strobe, 2 stop bits

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       line1, line2;
  logic [7:0] out1, out2;
  logic       done1, busy1, ferr1;
  logic       done2, busy2, ferr2;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  bit prev1    = 1'b0;
  bit prev2    = 1'b0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       hold_lvl;
    int         hold_cyc;
    int         gap;
  } vec_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  ev_t        obs2_q[$];
  int         done_log[$];
  logic [7:0] last_out;

  uart_rx #(.OVERSAMPLE(Os), .stop_bit_count(1)) dut1 (
    .rx_clock       (clk),
    .rx_reset_n     (rst_n),
    .rx_enable      (en),
    .rx_input       (line1),
    .rx_output      (out1),
    .rx_done        (done1),
    .rx_busy        (busy1),
    .rx_frame_error (ferr1)
  );

  uart_rx #(.OVERSAMPLE(Os), .stop_bit_count(2)) dut2 (
    .rx_clock       (clk),
    .rx_reset_n     (rst_n),
    .rx_enable      (en),
    .rx_input       (line2),
    .rx_output      (out2),
    .rx_done        (done2),
    .rx_busy        (busy2),
    .rx_frame_error (ferr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every strobe and flags overlapping or repeated ones.
  always @(negedge clk) begin
    if (done1 || ferr1) obs_q.push_back('{ferr1, out1, cyc});
    if (done2 || ferr2) obs2_q.push_back('{ferr2, out2, cyc});
    if ((done1 && ferr1) || (done2 && ferr2)) viol++;
    if (((done1 || ferr1) && prev1) || ((done2 || ferr2) && prev2)) viol++;
    prev1 = done1 || ferr1;
    prev2 = done2 || ferr2;
  end

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 1) line1 = v;
    else line2 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input int nstop,
                            input logic s0, input logic s1);
    set_line(which, 1'b0);
    hold(Os);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      hold(Os);
    end
    set_line(which, s0);
    hold(Os);
    if (nstop == 2) begin
      set_line(which, s1);
      hold(Os);
    end
  endtask

  // Match queued expectations against observed strobes of the 1-stop receiver.
  task automatic drain(input string name);
    int  t;
    ev_t e;
    ev_t o;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 400) begin
      step();
      t++;
    end
    chk({name, "_strobe_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({name, "_kind"}, int'(o.is_err), int'(e.is_err));
      chk({name, "_data"}, int'(o.data), int'(e.data));
      chk({name, "_cycle"}, o.cyc, e.cyc);
      if (!o.is_err) done_log.push_back(o.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Full frame on the 1-stop receiver with its expected result queued.
  task automatic frame1(input string name, input logic [7:0] d, input logic s0);
    exp_q.push_back('{!s0, d, cyc + LatOne});
    last_out = d;
    send_frame(1, d, 1, s0, 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    bit  saw_busy;
    int  e;
    ev_t o;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0,  20};  // nominal
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 40, 20};  // bad stop, then line held low
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0,  0};   // back-to-back pair
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 0,  20};
    vecs[4] = '{8'h69, 1'b1, 1'b1, 0,  20};

    rst_n    = 1'b1;
    en       = 1'b0;
    line1    = 1'b1;
    line2    = 1'b1;
    last_out = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_output", out1, 8'h00);
    chk("reset_busy", busy1, 0);
    chk("reset_done", done1, 0);
    chk("reset_ferr", ferr1, 0);
    hold(3);
    rst_n = 1'b1;
    en    = 1'b1;
    hold(5);

    // Table of frames.
    for (int i = 0; i < 5; i++) begin
      frame1("vec", vecs[i].data, vecs[i].stop);
      if (vecs[i].hold_cyc > 0) begin
        line1 = vecs[i].hold_lvl;
        hold(vecs[i].hold_cyc);
      end
      line1 = 1'b1;
      hold(vecs[i].gap);
      drain($sformatf("vec%0d", i));
    end
    if (done_log.size() >= 3) chk("b2b_spacing", done_log[2] - done_log[1], 160);
    else chk("b2b_done_count", done_log.size(), 3);

    // Glitch shorter than half a bit.
    line1 = 1'b0;
    hold(4);
    line1    = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy1) saw_busy = 1'b1;
    end
    chk("glitch_busy_seen", int'(saw_busy), 1);
    chk("glitch_busy_end", busy1, 0);
    chk("glitch_output", out1, last_out);
    drain("glitch");

    // Two-stop-bit receiver: good frame, then bad second stop bit.
    for (int k = 0; k < 2; k++) begin
      e = cyc + LatTwo;
      send_frame(2, 8'h81, 2, 1'b1, (k == 0));
      line2 = 1'b1;
      hold(20);
      chk("stop2_strobe_count", obs2_q.size(), 1);
      if (obs2_q.size() > 0) begin
        o = obs2_q.pop_front();
        chk("stop2_kind", int'(o.is_err), (k == 1) ? 1 : 0);
        chk("stop2_data", int'(o.data), 8'h81);
        chk("stop2_cycle", o.cyc, e);
      end
      obs2_q.delete();
    end

    // Abort via rx_enable at data bit 4.
    line1 = 1'b0;
    hold(Os);
    for (int i = 0; i < 4; i++) begin
      line1 = (i % 2 == 0);
      hold(Os);
    end
    line1 = 1'b1;
    hold(Os / 2);
    chk("abort_busy_before", busy1, 1);
    en = 1'b0;
    step();
    chk("abort_busy", busy1, 0);
    chk("abort_output_held", out1, last_out);
    hold(Os / 2 + 3 * Os);
    line1 = 1'b1;
    hold(Os + 20);
    en = 1'b1;
    hold(5);
    drain("abort");
    frame1("after_abort", 8'h5A, 1'b1);
    hold(20);
    drain("after_abort");

    // Asynchronous reset mid-frame.
    line1 = 1'b0;
    hold(Os);
    for (int i = 0; i < 3; i++) begin
      line1 = (i == 1);
      hold(Os);
    end
    chk("reset_mid_busy_before", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_output", out1, 8'h00);
    chk("reset_mid_busy", busy1, 0);
    chk("reset_mid_done", done1, 0);
    chk("reset_mid_ferr", ferr1, 0);
    last_out = 8'h00;
    line1    = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    hold(5);
    drain("reset_mid");
    frame1("after_reset", 8'h5A, 1'b1);
    hold(20);
    drain("after_reset");
    chk("final_output", out1, 8'h5A);

    chk("strobe_rules", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
